// File: rtl/mmio_to_axi4_lite_master_pkg.sv
// Shared types for the MMIO-to-AXI4-Lite master bridge: FSM state encoding
// and AXI response codes with a helper that classifies a response as failed.
package mmio_to_axi4_lite_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_WRITE          = 3'd1,
        ST_WRITE_RESPONSE = 3'd2,
        ST_READ           = 3'd3,
        ST_READ_DATA      = 3'd4
    } bridge_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [15:0] ERROR_COUNT_MAX = 16'hFFFF;

    function automatic logic resp_is_error(input logic [1:0] resp);
        logic err;
        case (resp)
            RESP_OKAY, RESP_EXOKAY:   err = 1'b0;
            RESP_SLVERR, RESP_DECERR: err = 1'b1;
            default:                  err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/mmio_to_axi4_lite_master.sv
// Single-outstanding MMIO-to-AXI4-Lite master: AW and W issued together,
// every response checked, optional timeout that abandons a stuck transaction.
module mmio_to_axi4_lite_master
    import mmio_to_axi4_lite_master_pkg::*;
#(
    parameter int                                   AXI4_LITE_ADDRESS_WIDTH = 32,
    parameter int                                   AXI4_LITE_DATA_WIDTH    = 32,
    parameter logic [AXI4_LITE_ADDRESS_WIDTH-1:0]   BASE_ADDRESS            = '0,
    parameter int unsigned                          TIMEOUT_CYCLES          = 1024
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    read_req,
    input  logic                                    write_req,
    input  logic [AXI4_LITE_ADDRESS_WIDTH-1:0]      index,
    input  logic [AXI4_LITE_DATA_WIDTH-1:0]         write_data,
    output logic                                    read_ack,
    output logic                                    write_ack,
    output logic [AXI4_LITE_DATA_WIDTH-1:0]         read_data,
    output logic [AXI4_LITE_ADDRESS_WIDTH-1:0]      M_AXI_AWADDR,
    output logic [2:0]                              M_AXI_AWPROT,
    output logic                                    M_AXI_AWVALID,
    input  logic                                    M_AXI_AWREADY,
    output logic [AXI4_LITE_DATA_WIDTH-1:0]         M_AXI_WDATA,
    output logic [AXI4_LITE_DATA_WIDTH/8-1:0]       M_AXI_WSTRB,
    output logic                                    M_AXI_WVALID,
    input  logic                                    M_AXI_WREADY,
    input  logic [1:0]                              M_AXI_BRESP,
    input  logic                                    M_AXI_BVALID,
    output logic                                    M_AXI_BREADY,
    output logic [AXI4_LITE_ADDRESS_WIDTH-1:0]      M_AXI_ARADDR,
    output logic [2:0]                              M_AXI_ARPROT,
    output logic                                    M_AXI_ARVALID,
    input  logic                                    M_AXI_ARREADY,
    input  logic [AXI4_LITE_DATA_WIDTH-1:0]         M_AXI_RDATA,
    input  logic [1:0]                              M_AXI_RRESP,
    input  logic                                    M_AXI_RVALID,
    output logic                                    M_AXI_RREADY,
    output logic                                    error,
    output logic [15:0]                             error_count
);

    localparam int          BYTE_SHIFT   = $clog2(AXI4_LITE_DATA_WIDTH / 8);
    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 32'd0);
    localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;

    bridge_state_e                        state_q, state_d;
    logic [AXI4_LITE_ADDRESS_WIDTH-1:0]   addr_q, addr_d;
    logic [AXI4_LITE_DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic [AXI4_LITE_DATA_WIDTH-1:0]      read_data_q, read_data_d;
    logic                                 awvalid_q, awvalid_d;
    logic                                 wvalid_q, wvalid_d;
    logic                                 aw_done_q, aw_done_d;
    logic                                 w_done_q, w_done_d;
    logic                                 bready_q, bready_d;
    logic                                 arvalid_q, arvalid_d;
    logic                                 rready_q, rready_d;
    logic                                 read_ack_q, read_ack_d;
    logic                                 write_ack_q, write_ack_d;
    logic                                 error_q, error_d;
    logic [15:0]                          error_count_q, error_count_d;
    logic [31:0]                          timer_q, timer_d;
    logic                                 err_event_s;
    logic                                 timeout_hit_s;

    // Next-state, handshake tracking, timeout abort and error accounting.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        read_data_d   = read_data_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        read_ack_d    = 1'b0;
        write_ack_d   = 1'b0;
        error_d       = error_q;
        error_count_d = error_count_q;
        timer_d       = timer_q;
        err_event_s   = 1'b0;
        timeout_hit_s = TIMEOUT_EN && (state_q != ST_IDLE) && (timer_q == TIMEOUT_LAST);

        case (state_q)
            ST_IDLE: begin
                if (write_req) begin
                    state_d   = ST_WRITE;
                    addr_d    = BASE_ADDRESS + (index << BYTE_SHIFT);
                    wdata_d   = write_data;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else if (read_req) begin
                    state_d   = ST_READ;
                    addr_d    = BASE_ADDRESS + (index << BYTE_SHIFT);
                    arvalid_d = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (awvalid_q && M_AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end else begin
                    aw_done_d = aw_done_q;
                end
                if (wvalid_q && M_AXI_WREADY) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end else begin
                    w_done_d = w_done_q;
                end
                if (aw_done_d && w_done_d) begin
                    state_d  = ST_WRITE_RESPONSE;
                    bready_d = 1'b1;
                end else begin
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE_RESPONSE: begin
                if (M_AXI_BVALID) begin
                    state_d     = ST_IDLE;
                    bready_d    = 1'b0;
                    write_ack_d = 1'b1;
                    err_event_s = resp_is_error(M_AXI_BRESP);
                end else begin
                    state_d     = ST_WRITE_RESPONSE;
                end
            end
            ST_READ: begin
                if (M_AXI_ARREADY) begin
                    state_d   = ST_READ_DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else begin
                    state_d   = ST_READ;
                end
            end
            ST_READ_DATA: begin
                if (M_AXI_RVALID) begin
                    state_d     = ST_IDLE;
                    rready_d    = 1'b0;
                    read_ack_d  = 1'b1;
                    read_data_d = M_AXI_RDATA;
                    err_event_s = resp_is_error(M_AXI_RRESP);
                end else begin
                    state_d     = ST_READ_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A stalled transaction is abandoned only if nothing completed this cycle.
        if (timeout_hit_s && (state_d == state_q)) begin
            state_d     = ST_IDLE;
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            err_event_s = 1'b1;
            timer_d     = 32'd0;
            if ((state_q == ST_READ) || (state_q == ST_READ_DATA)) begin
                read_ack_d  = 1'b1;
                read_data_d = '0;
            end else begin
                write_ack_d = 1'b1;
            end
        end else if (state_d != state_q) begin
            timer_d = 32'd0;
        end else if (state_q != ST_IDLE) begin
            timer_d = timer_q + 32'd1;
        end else begin
            timer_d = 32'd0;
        end

        if (err_event_s) begin
            error_d = 1'b1;
            if (error_count_q != ERROR_COUNT_MAX) begin
                error_count_d = error_count_q + 16'd1;
            end else begin
                error_count_d = error_count_q;
            end
        end else begin
            error_d = error_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            read_data_q   <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            read_ack_q    <= 1'b0;
            write_ack_q   <= 1'b0;
            error_q       <= 1'b0;
            error_count_q <= 16'd0;
            timer_q       <= 32'd0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            read_data_q   <= read_data_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            read_ack_q    <= read_ack_d;
            write_ack_q   <= write_ack_d;
            error_q       <= error_d;
            error_count_q <= error_count_d;
            timer_q       <= timer_d;
        end
    end

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = {(AXI4_LITE_DATA_WIDTH/8){1'b1}};
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
    assign read_ack      = read_ack_q;
    assign write_ack     = write_ack_q;
    assign read_data     = read_data_q;
    assign error         = error_q;
    assign error_count   = error_count_q;

endmodule

// File: doc/mmio_to_axi4_lite_master.md
Name: mmio_to_axi4_lite_master

Overview:
Bridges a generic MMIO request stream onto an AXI4-Lite master port. This is the initiator-side counterpart of the AXI4-Lite-to-MMIO slave bridge. It lets on-fabric logic (test sequencers, a future control processor) drive any AXI4-Lite slave, including another test system's register space. Only one transaction is in flight at a time; AW and W are issued concurrently, and all responses are checked.

Parameters:
AXI4_LITE_ADDRESS_WIDTH, 32, AXI address width.
AXI4_LITE_DATA_WIDTH, 32, AXI data width; must be 32 or 64.
BASE_ADDRESS, 0, byte address added to every translated MMIO index.
TIMEOUT_CYCLES, 1024, cycles a transaction may wait before being aborted; 0 disables the timeout.

Ports:
clock  input  1  positive-edge clock
reset  input  1  synchronous, active-high
host_interface  mmio_if (device side)  -  request side: read_req, write_req, index, write_data; response side: read_ack, write_ack, read_data
M_AXI_AWADDR  output  AXI4_LITE_ADDRESS_WIDTH  write address
M_AXI_AWPROT  output  3  tied 3'b000
M_AXI_AWVALID  output  1  write address valid
M_AXI_AWREADY  input  1  write address ready
M_AXI_WDATA  output  AXI4_LITE_DATA_WIDTH  write data
M_AXI_WSTRB  output  AXI4_LITE_DATA_WIDTH/8  tied all ones
M_AXI_WVALID  output  1  write data valid
M_AXI_WREADY  input  1  write data ready
M_AXI_BRESP  input  2  write response
M_AXI_BVALID  input  1  write response valid
M_AXI_BREADY  output  1  write response ready
M_AXI_ARADDR  output  AXI4_LITE_ADDRESS_WIDTH  read address
M_AXI_ARPROT  output  3  tied 3'b000
M_AXI_ARVALID  output  1  read address valid
M_AXI_ARREADY  input  1  read address ready
M_AXI_RDATA  input  AXI4_LITE_DATA_WIDTH  read data
M_AXI_RRESP  input  2  read response
M_AXI_RVALID  input  1  read data valid
M_AXI_RREADY  output  1  read data ready
error  output  1  sticky; set on non-OKAY response or timeout; cleared only by reset
error_count  output  16  saturating count of errored transactions

Behaviour:
- Reset (synchronous, active-high): state IDLE; all VALID/READY outputs, read_ack, write_ack, error and error_count are 0; address and data registers are 0.
- Address translation: addr = BASE_ADDRESS + (index << log2(DATA_WIDTH/8)). Truncate to the address width; wrap-around is allowed.
- IDLE:
  - Accepts a request only in IDLE. It captures index and write_data in the same cycle.
  - write_req has priority when both read_req and write_req are high. The read is not lost: the requester holds read_req, so it is served after the write completes.
- WRITE: AWVALID and WVALID assert on the cycle after capture.
  - Each channel drops independently on its own handshake. The aw_done and w_done flags track completion.
  - When both are done, go to WRITE_RESPONSE.
  - VALID is never deasserted before its READY; address and data are held stable.
- WRITE_RESPONSE: BREADY = 1. On BVALID, pulse write_ack for exactly one cycle and return to IDLE.
- READ: ARVALID is held until ARREADY, then go to READ_DATA.
- READ_DATA: RREADY = 1. On RVALID, register RDATA into read_data, pulse read_ack for one cycle, and return to IDLE.
- Minimum latency from request to ack with zero-wait slaves:
  - write: 3 cycles (capture, AW/W handshake, B handshake + ack)
  - read: 3 cycles.
- Response errors: BRESP/RRESP of SLVERR or DECERR sets error and increments error_count (saturating at 0xFFFF). The ack is still issued; read_data on a read error is RDATA as returned.
- Timeout: a counter restarts at every state entry. Reaching TIMEOUT_CYCLES in any non-IDLE state does all of the following:
  - forces error and increments error_count;
  - issues the ack with read_data = 0;
  - deasserts all VALID/READY and returns to IDLE.
  - Note: an abandoned AXI transaction violates the protocol. Timeout is a debug aid only.
- Reset mid-transaction: outputs drop immediately on the reset edge. No response is generated for the aborted request.
- New requests arriving while busy are ignored (not queued). The requester must hold its request until acked.

Decomposition:
- Shared package: the bridge state enum (IDLE, WRITE, WRITE_RESPONSE, READ, READ_DATA) and the AXI response constants (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11).
- Sub-module: none. The FSM, counters and channel flags all fit in one module.

Test Plan:
1. Write index 5, data 0xDEADBEEF, BASE_ADDRESS 0x1000, zero-wait slave -> AWADDR 0x1014, WDATA 0xDEADBEEF, WSTRB 0xF; write_ack pulses once, 3 cycles after capture.
2. Slave gives AWREADY 4 cycles before WREADY -> AWVALID drops after its handshake, WVALID is held; B accepted only after both handshakes; a single write_ack.
3. Read index 2, slave returns 0x12345678 after 6-cycle RVALID delay -> ARADDR 0x1008; read_data = 0x12345678 coincident with a single-cycle read_ack.
4. read_req and write_req asserted in the same cycle -> write completes first; read then issues; exactly two acks, in order.
5. Read where slave returns RRESP=SLVERR -> error = 1, error_count = 1; read_ack still pulses; a following OKAY write leaves error at 1.
6. TIMEOUT_CYCLES = 16, slave never asserts ARREADY -> ARVALID drops after 16 cycles; read_ack with read_data 0; error = 1; FSM returns to IDLE and accepts the next request.
